// File: rtl/data_cb_config_loader_pkg.sv
// Shared types and sizing helpers for the data connection block configuration loader.
// Provides the loader state enum, the default beat width and the beat-count helper.
package data_cb_cfg_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    COMMIT = 2'd2
  } state_e;

  localparam int unsigned CHUNK_DEF   = 32'd32;
  localparam int unsigned W_DEF       = 32'd16;
  localparam int unsigned DATAIN_DEF  = 32'd8;
  localparam int unsigned DATAOUT_DEF = 32'd16;

  // Beats needed to cover conf_width bits, rounding up.
  function automatic int unsigned nchunk(input int unsigned conf_width, input int unsigned chunk);
    return (conf_width + chunk - 32'd1) / chunk;
  endfunction

  localparam int unsigned NCHUNK_DEF = nchunk(W_DEF * (DATAIN_DEF + DATAOUT_DEF), CHUNK_DEF);
  localparam int unsigned CNT_W_DEF  = $clog2(NCHUNK_DEF);

endpackage

// File: rtl/data_cb_config_loader_if.sv
// Configuration beat stream (valid/ready) feeding the loader.
// The optional cfg_par bit exists only when CFG_PARITY_EN is defined.
interface data_cb_config_loader_if
  import data_cb_cfg_pkg::*;
#(
  parameter int unsigned CHUNK = CHUNK_DEF
) ();

  logic [CHUNK-1:0] cfg_data;
  logic             cfg_valid;
  logic             cfg_ready;
`ifdef CFG_PARITY_EN
  logic             cfg_par;

  modport master (output cfg_data, output cfg_valid, output cfg_par, input cfg_ready);
  modport slave  (input cfg_data, input cfg_valid, input cfg_par, output cfg_ready);
`else
  modport master (output cfg_data, output cfg_valid, input cfg_ready);
  modport slave  (input cfg_data, input cfg_valid, output cfg_ready);
`endif

endinterface

// File: rtl/data_cb_config_loader.sv
// Assembles CHUNK-bit beats into the connection block shadow and commits it with a one-cycle cset.
// Optional feature macro CFG_PARITY_EN: even parity per beat, a failed load ends with err instead of cset.
module data_cb_config_loader
  import data_cb_cfg_pkg::*;
#(
  parameter int unsigned W          = 32'd16,
  parameter int unsigned DATAIN     = 32'd8,
  parameter int unsigned DATAOUT    = 32'd16,
  parameter int unsigned CHUNK      = CHUNK_DEF,
  parameter int unsigned CONF_WIDTH = W * (DATAIN + DATAOUT)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   abort,
  data_cb_config_loader_if.slave cfg,
  output logic [CONF_WIDTH-1:0]  c,
  output logic                   cset,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  localparam int unsigned NCHUNK = nchunk(CONF_WIDTH, CHUNK);
  localparam int unsigned CNT_W  = (NCHUNK > 32'd1) ? $clog2(NCHUNK) : 32'd1;
  localparam int unsigned PAD_W  = NCHUNK * CHUNK;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NCHUNK - 32'd1);

  state_e                  state_r, state_s;
  logic [CNT_W-1:0]        cnt_r, cnt_s;
  logic [CONF_WIDTH-1:0]   c_r, c_s;
  logic [PAD_W-1:0]        pad_s;
  logic                    par_err_r, par_err_s;
  logic                    beat_bad_s;
  logic                    xfer_s;
  logic                    err_s;
  logic                    cfg_ready_r, cset_r, busy_r, done_r, err_r;

`ifdef CFG_PARITY_EN
  assign beat_bad_s = (^cfg.cfg_data) ^ cfg.cfg_par;
`else
  assign beat_bad_s = 1'b0;
`endif

  assign xfer_s = cfg.cfg_valid & cfg_ready_r;

  // Next-state, beat placement and error decision; abort beats any beat presented with it.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    c_s       = c_r;
    par_err_s = par_err_r;
    err_s     = 1'b0;
    pad_s     = '0;
    pad_s[CONF_WIDTH-1:0] = c_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s   = LOAD;
          cnt_s     = '0;
          par_err_s = 1'b0;
        end else begin
          state_s   = IDLE;
        end
      end
      LOAD: begin
        if (abort) begin
          state_s = IDLE;
          err_s   = 1'b1;
        end else if (xfer_s) begin
          // Padding absorbs the bits of the last beat that lie beyond CONF_WIDTH.
          pad_s[cnt_r*CHUNK +: CHUNK] = cfg.cfg_data;
          c_s       = pad_s[CONF_WIDTH-1:0];
          cnt_s     = cnt_r + CNT_W'(1);
          par_err_s = par_err_r | beat_bad_s;
          if (cnt_r == LAST_CNT) begin
            if (par_err_r | beat_bad_s) begin
              state_s = IDLE;
              err_s   = 1'b1;
            end else begin
              state_s = COMMIT;
            end
          end else begin
            state_s = LOAD;
          end
        end else begin
          state_s = LOAD;
        end
      end
      COMMIT: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, shadow and registered handshake/status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      cnt_r       <= '0;
      c_r         <= '0;
      par_err_r   <= 1'b0;
      cfg_ready_r <= 1'b0;
      cset_r      <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      c_r         <= c_s;
      par_err_r   <= par_err_s;
      cfg_ready_r <= (state_s == LOAD);
      cset_r      <= (state_s == COMMIT);
      busy_r      <= (state_s == LOAD) || (state_s == COMMIT);
      done_r      <= (state_s == COMMIT);
      err_r       <= err_s;
    end
  end

  assign cfg.cfg_ready = cfg_ready_r;
  assign c             = c_r;
  assign cset          = cset_r;
  assign busy          = busy_r;
  assign done          = done_r;
  assign err           = err_r;

endmodule

// File: tb/tb_data_cb_config_loader.sv
// Randomized self-checking bench for data_cb_config_loader against a beat-array reference model.
// Parity scenarios are included when CFG_PARITY_EN is defined.
module tb_data_cb_config_loader;
  import data_cb_cfg_pkg::*;

  localparam int CONF = 384;
  localparam int CH   = 32;
  localparam int NCH  = 12;

  logic clk;
  logic rst_n;
  logic start;
  logic abort;
  logic [CONF-1:0] c;
  logic cset, busy, done, err;

  int checks;
  int errors;
  int cset_seen;
  logic [CH-1:0] model_w [NCH];

  data_cb_config_loader_if #(.CHUNK(CH)) bus ();

  data_cb_config_loader dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .abort (abort),
    .cfg   (bus),
    .c     (c),
    .cset  (cset),
    .busy  (busy),
    .done  (done),
    .err   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (cset) cset_seen = cset_seen + 1;
  end

  task automatic check_eq(input string tag, input logic [CONF-1:0] got, input logic [CONF-1:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [CONF-1:0] model_c();
    logic [CONF-1:0] r;
    for (int i = 0; i < NCH; i++) r[i*CH +: CH] = model_w[i];
    return r;
  endfunction

  task automatic drive_beat(input logic [CH-1:0] w, input bit bad);
    bus.cfg_valid = 1'b1;
    bus.cfg_data  = w;
`ifdef CFG_PARITY_EN
    bus.cfg_par   = (^w) ^ bad;
`endif
  endtask

  task automatic idle_bus();
    bus.cfg_valid = 1'b0;
    bus.cfg_data  = $urandom;
`ifdef CFG_PARITY_EN
    bus.cfg_par   = ^bus.cfg_data;
`endif
  endtask

  // stall: 0 none, 1 gap before every beat, 2 random gaps
  task automatic run_load(input int stall, input int abort_k, input int start_k,
                          input int badpar_k, input bit fixed_data);
    int base;
    bit aborted;
    logic [CH-1:0] word;
    base = cset_seen;
    aborted = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    check_eq("busy_in_load", busy, 1'b1);
    check_eq("ready_in_load", bus.cfg_ready, 1'b1);
    for (int k = 0; k < NCH; k++) begin
      if (stall == 1 || (stall == 2 && $urandom_range(0, 1) == 1)) begin
        idle_bus();
        step();
        check_eq("ready_stall", bus.cfg_ready, 1'b1);
        check_eq("cset_stall", cset, 1'b0);
      end
      word = fixed_data ? CH'(k + 1) : CH'($urandom);
      drive_beat(word, k == badpar_k);
      abort = (k == abort_k);
      start = (k == start_k);
      step();
      abort = 1'b0;
      start = 1'b0;
      idle_bus();
      if (k == abort_k) begin
        aborted = 1'b1;
        break;
      end
      model_w[k] = word;
      if (k < NCH - 1) check_eq("cset_mid_load", cset, 1'b0);
    end
    if (aborted) begin
      check_eq("abort_err", err, 1'b1);
      check_eq("abort_cset", cset, 1'b0);
      check_eq("abort_busy", busy, 1'b0);
      check_eq("abort_c_partial", c, model_c());
      step();
      check_eq("abort_err_pulse", err, 1'b0);
      check_eq("abort_no_commit", cset_seen, base);
    end else if (badpar_k >= 0) begin
      check_eq("par_err", err, 1'b1);
      check_eq("par_cset", cset, 1'b0);
      check_eq("par_done", done, 1'b0);
      check_eq("par_busy", busy, 1'b0);
      step();
      check_eq("par_no_commit", cset_seen, base);
    end else begin
      check_eq("commit_cset", cset, 1'b1);
      check_eq("commit_done", done, 1'b1);
      check_eq("commit_err", err, 1'b0);
      check_eq("commit_c", c, model_c());
      step();
      check_eq("post_cset", cset, 1'b0);
      check_eq("post_done", done, 1'b0);
      check_eq("post_busy", busy, 1'b0);
      check_eq("post_c_hold", c, model_c());
      check_eq("commit_count", cset_seen, base + 1);
    end
  endtask

  initial begin
    int base;
    checks = 0;
    errors = 0;
    cset_seen = 0;
    for (int i = 0; i < NCH; i++) model_w[i] = '0;
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    idle_bus();
    step();
    step();
    check_eq("rst_c", c, '0);
    check_eq("rst_ready", bus.cfg_ready, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_cset", cset, 1'b0);
    check_eq("rst_done", done, 1'b0);
    check_eq("rst_err", err, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // abort while idle is ignored
    abort = 1'b1;
    step();
    abort = 1'b0;
    check_eq("idle_abort_err", err, 1'b0);
    check_eq("idle_abort_busy", busy, 1'b0);

    // reset mid-load after five beats
    base = cset_seen;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      drive_beat(CH'($urandom), 1'b0);
      step();
    end
    idle_bus();
    #3;
    rst_n = 1'b0;
    #1;
    check_eq("midrst_c", c, '0);
    check_eq("midrst_busy", busy, 1'b0);
    check_eq("midrst_cset", cset, 1'b0);
    for (int i = 0; i < NCH; i++) model_w[i] = '0;
    step();
    @(negedge clk);
    rst_n = 1'b1;
    step();
    step();
    check_eq("midrst_busy_after", busy, 1'b0);
    check_eq("midrst_c_after", c, '0);
    check_eq("midrst_no_cset", cset_seen, base);

    // full load with beats 1..12
    run_load(0, -1, -1, -1, 1'b1);
    check_eq("full_low_word", c[31:0], 32'h1);
    check_eq("full_high_word", c[383:352], 32'hC);

    // stalled source, same data
    run_load(1, -1, -1, -1, 1'b1);
    check_eq("stall_low_word", c[31:0], 32'h1);
    check_eq("stall_high_word", c[383:352], 32'hC);

    // abort racing the final beat, then a normal load
    run_load(0, NCH - 1, -1, -1, 1'b0);
    run_load(0, -1, -1, -1, 1'b0);

    // start pulsed during load at beat 4
    run_load(0, -1, 3, -1, 1'b0);

`ifdef CFG_PARITY_EN
    run_load(0, -1, -1, 6, 1'b0);
    run_load(0, -1, -1, -1, 1'b1);
    check_eq("par_ok_low_word", c[31:0], 32'h1);
`endif

    for (int r = 0; r < 8; r++) begin
      int ak;
      int pk;
      ak = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, NCH - 1)) : -1;
      pk = -1;
`ifdef CFG_PARITY_EN
      if (ak < 0 && $urandom_range(0, 2) == 0) pk = int'($urandom_range(0, NCH - 1));
`endif
      run_load(2, ak, -1, pk, 1'b0);
      if (pk >= 0) begin
        run_load(0, -1, -1, -1, 1'b0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
